// File: rtl/alu_issue.sv
// Single-entry issue buffer between decode and the ALU, with one tracked in-flight write.
// Latency: at least 1 cycle from accept to issue; a dependent op waits for its producer's result.
// Backpressure: o_ready drops while the buffered op cannot issue (ALU busy or hazard).
// Define ALU_ISSUE_BYPASS_EN to forward i_alu_c straight onto o_a/o_b in the cycle the result returns.
module alu_issue (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_areg,
    input  logic [4:0]  i_breg,
    input  logic [4:0]  i_wreg,
    input  logic        i_wen,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_stb,
    output logic [3:0]  o_op,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    input  logic        i_alu_valid,
    input  logic        i_alu_busy,
    input  logic [31:0] i_alu_c,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_reg,
    output logic [31:0] o_wb_data
);

    logic        buf_valid_q, buf_valid_d;
    logic [3:0]  buf_op_q, buf_op_d;
    logic [4:0]  buf_areg_q, buf_areg_d;
    logic [4:0]  buf_breg_q, buf_breg_d;
    logic [4:0]  buf_wreg_q, buf_wreg_d;
    logic        buf_wen_q, buf_wen_d;
    logic [31:0] buf_a_q, buf_a_d;
    logic [31:0] buf_b_q, buf_b_d;
    logic        inflight_q, inflight_d;
    logic [4:0]  inflight_reg_q, inflight_reg_d;

    logic        ret_vld;
    logic        a_match;
    logic        b_match;
    logic        resolved;
    logic        a_fwd;
    logic        b_fwd;
    logic        hazard;
    logic        issue;
    logic        accept;

    // Decide whether the buffered op may issue this cycle and whether a new op is accepted.
    always_comb begin
        ret_vld = i_alu_valid && inflight_q;
        a_match = (buf_areg_q == inflight_reg_q);
        b_match = (buf_breg_q == inflight_reg_q);
`ifdef ALU_ISSUE_BYPASS_EN
        // The returning result is muxed onto the operand, so the dependency clears immediately.
        resolved = ret_vld;
        a_fwd    = ret_vld && a_match;
        b_fwd    = ret_vld && b_match;
`else
        // The buffered operand is patched at the edge; the dependent op issues one cycle later.
        resolved = 1'b0;
        a_fwd    = 1'b0;
        b_fwd    = 1'b0;
`endif
        hazard = inflight_q && (a_match || b_match) && !resolved;
        issue  = buf_valid_q && !i_alu_busy && !hazard;
        accept = i_valid && (!buf_valid_q || issue);
    end

    // Drive the ALU issue port and the register-file write port.
    always_comb begin
        o_ready    = !buf_valid_q || issue;
        o_stb      = issue;
        o_op       = buf_op_q;
        o_a        = a_fwd ? i_alu_c : buf_a_q;
        o_b        = b_fwd ? i_alu_c : buf_b_q;
        o_wb_valid = ret_vld;
        o_wb_reg   = inflight_reg_q;
        o_wb_data  = i_alu_c;
    end

    // Next state of the op buffer and the in-flight write tracker.
    always_comb begin
        buf_valid_d    = buf_valid_q;
        buf_op_d       = buf_op_q;
        buf_areg_d     = buf_areg_q;
        buf_breg_d     = buf_breg_q;
        buf_wreg_d     = buf_wreg_q;
        buf_wen_d      = buf_wen_q;
        buf_a_d        = buf_a_q;
        buf_b_d        = buf_b_q;
        inflight_d     = inflight_q;
        inflight_reg_d = inflight_reg_q;

        if (accept) begin
            // A source written by the returning result takes i_alu_c: the regfile read is still stale.
            buf_valid_d = 1'b1;
            buf_op_d    = i_op;
            buf_areg_d  = i_areg;
            buf_breg_d  = i_breg;
            buf_wreg_d  = i_wreg;
            buf_wen_d   = i_wen;
            buf_a_d     = (ret_vld && (i_areg == inflight_reg_q)) ? i_alu_c : i_a;
            buf_b_d     = (ret_vld && (i_breg == inflight_reg_q)) ? i_alu_c : i_b;
        end else begin
            if (issue) begin
                buf_valid_d = 1'b0;
            end
            // Keep a waiting op's operands current with the result it depends on.
            if (ret_vld && a_match) begin
                buf_a_d = i_alu_c;
            end
            if (ret_vld && b_match) begin
                buf_b_d = i_alu_c;
            end
        end

        // A new write issuing in the same cycle a result returns wins over the clear.
        if (i_alu_valid) begin
            inflight_d = 1'b0;
        end
        if (issue && buf_wen_q) begin
            inflight_d     = 1'b1;
            inflight_reg_d = buf_wreg_q;
        end

        if (i_reset) begin
            buf_valid_d = 1'b0;
            inflight_d  = 1'b0;
        end
    end

    // State registers; reset is folded into the next-state logic so data flops stay unreset.
    always_ff @(posedge i_clk) begin
        buf_valid_q    <= buf_valid_d;
        buf_op_q       <= buf_op_d;
        buf_areg_q     <= buf_areg_d;
        buf_breg_q     <= buf_breg_d;
        buf_wreg_q     <= buf_wreg_d;
        buf_wen_q      <= buf_wen_d;
        buf_a_q        <= buf_a_d;
        buf_b_q        <= buf_b_d;
        inflight_q     <= inflight_d;
        inflight_reg_q <= inflight_reg_d;
    end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed scenarios with explicit cycle checks, then randomized traffic.
// Expected issue operands and writebacks come from a program-order register model.
// A separate monitor pops the expectation queues whenever the DUT strobes or writes back.
module tb_alu_issue;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MPY = 4'd6;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_op = 4'd0;
    logic [4:0]  i_areg = 5'd0;
    logic [4:0]  i_breg = 5'd0;
    logic [4:0]  i_wreg = 5'd0;
    logic        i_wen = 1'b0;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_stb;
    logic [3:0]  o_op;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic        i_alu_valid;
    logic        i_alu_busy;
    logic [31:0] i_alu_c;
    logic        o_wb_valid;
    logic [4:0]  o_wb_reg;
    logic [31:0] o_wb_data;

    iss_t        iss_q[$];
    wb_t         wb_q[$];
    logic [31:0] alu_q[$];

    logic [31:0] env_rf[32];
    logic [31:0] init_val[32];
    logic [31:0] mrf[32];
    logic        rf_load = 1'b0;

    logic        auto_mode = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_busy = 1'b0;
    logic [31:0] a_c = 32'd0;
    logic        d_valid = 1'b0;
    logic        d_busy = 1'b0;
    logic [31:0] d_c = 32'd0;

    int n_chk = 0;
    int n_fail = 0;

    assign i_a         = env_rf[i_areg];
    assign i_b         = env_rf[i_breg];
    assign i_alu_valid = auto_mode ? a_valid : d_valid;
    assign i_alu_busy  = auto_mode ? a_busy : d_busy;
    assign i_alu_c     = auto_mode ? a_c : d_c;

    alu_issue dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_areg     (i_areg),
        .i_breg     (i_breg),
        .i_wreg     (i_wreg),
        .i_wen      (i_wen),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_stb      (o_stb),
        .o_op       (o_op),
        .o_a        (o_a),
        .o_b        (o_b),
        .i_alu_valid(i_alu_valid),
        .i_alu_busy (i_alu_busy),
        .i_alu_c    (i_alu_c),
        .o_wb_valid (o_wb_valid),
        .o_wb_reg   (o_wb_reg),
        .o_wb_data  (o_wb_data)
    );

    initial forever #5 i_clk = ~i_clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a * b;
            default: return a + b + {28'd0, op};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file seen by decode: bulk load from the bench, otherwise written by the DUT's port.
    always @(posedge i_clk) begin
        if (rf_load) begin
            env_rf <= init_val;
        end else if (o_wb_valid === 1'b1) begin
            env_rf[o_wb_reg] <= o_wb_data;
        end
    end

    // ALU stand-in: queues a result per strobe; in auto mode returns it after 1..3 cycles.
    initial begin
        int   left;
        logic pend;
        left = 0;
        pend = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset === 1'b0 && o_stb === 1'b1) begin
                alu_q.push_back(alu_f(o_op, o_a, o_b));
                if (auto_mode) begin
                    pend = 1'b1;
                    left = $urandom_range(1, 3);
                end
            end
            @(posedge i_clk);
            #1;
            a_valid = 1'b0;
            a_busy  = 1'b0;
            if (auto_mode && pend) begin
                left--;
                if (left == 0) begin
                    pend    = 1'b0;
                    a_valid = 1'b1;
                    a_c     = (alu_q.size() != 0) ? alu_q.pop_front() : 32'd0;
                end else begin
                    a_busy = 1'b1;
                end
            end
            if (auto_mode && $urandom_range(0, 7) == 0) a_busy = 1'b1;
        end
    end

    // Monitor: every strobe and every writeback must match the oldest expectation.
    initial begin
        iss_t e;
        wb_t  w;
        forever begin
            @(negedge i_clk);
            if (i_reset === 1'b0) begin
                if (o_stb !== 1'b0) begin
                    chk("stb_while_busy", {31'd0, i_alu_busy}, 32'd0);
                    if (iss_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_issue: op %0d a 0x%08h b 0x%08h with nothing expected", o_op, o_a, o_b);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue_op", {28'd0, o_op}, {28'd0, e.op});
                        chk("issue_a", o_a, e.a);
                        chk("issue_b", o_b, e.b);
                    end
                end
                if (o_wb_valid !== 1'b0) begin
                    if (wb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_wb: reg %0d data 0x%08h with nothing expected", o_wb_reg, o_wb_data);
                    end else begin
                        w = wb_q.pop_front();
                        chk("wb_reg", {27'd0, o_wb_reg}, {27'd0, w.r});
                        chk("wb_data", o_wb_data, w.d);
                    end
                end
            end
        end
    end

    // One clock of stimulus; accepted ops update the program-order model and expectation queues.
    task automatic cyc(input logic rst, input logic v, input logic [3:0] op, input logic [4:0] ar,
                       input logic [4:0] br, input logic [4:0] wr, input logic wen,
                       input logic av, input logic bsy);
        iss_t        e;
        wb_t         w;
        @(posedge i_clk);
        #1;
        rf_load = 1'b0;
        i_reset = rst;
        i_valid = v;
        i_op    = op;
        i_areg  = ar;
        i_breg  = br;
        i_wreg  = wr;
        i_wen   = wen;
        d_busy  = bsy;
        d_valid = av;
        if (av) d_c = (alu_q.size() != 0) ? alu_q.pop_front() : 32'd0;
        #1;
        if (i_valid && o_ready === 1'b1 && !i_reset) begin
            e.op = op;
            e.a  = mrf[ar];
            e.b  = mrf[br];
            iss_q.push_back(e);
            if (wen) begin
                w.r = wr;
                w.d = alu_f(op, e.a, e.b);
                mrf[wr] = w.d;
                wb_q.push_back(w);
            end
        end
    endtask

    task automatic idle(input logic av, input logic bsy);
        cyc(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, av, bsy);
    endtask

    task automatic load_rf();
        for (int i = 0; i < 32; i++) begin
            init_val[i] = $urandom;
        end
        init_val[3]  = 32'd2;
        init_val[5]  = 32'd5;
        init_val[6]  = 32'd7;
        init_val[10] = 32'hDEAD0000;
        init_val[11] = 32'h0000BEEF;
        mrf     = init_val;
        rf_load = 1'b1;
    endtask

    initial begin
        // Reset and state in the following cycle.
        load_rf();
        cyc(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_stb", {31'd0, o_stb}, 32'd0);
        chk("reset_wb_valid", {31'd0, o_wb_valid}, 32'd0);

        // Independent ops back to back: ADD r1=r2+r3, OR r4=r5|r6.
        cyc(1'b0, 1'b1, OP_ADD, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("indep_ready0", {31'd0, o_ready}, 32'd1);
        cyc(1'b0, 1'b1, OP_OR, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("indep_stb1", {31'd0, o_stb}, 32'd1);
        chk("indep_ready1", {31'd0, o_ready}, 32'd1);
        idle(1'b1, 1'b0);
        chk("indep_stb2", {31'd0, o_stb}, 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Dependent op: ADD r1=5+7, then SUB r2=r1-r3 with a two-cycle ALU.
        cyc(1'b0, 1'b1, OP_ADD, 5'd5, 5'd6, 5'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_SUB, 5'd1, 5'd3, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("dep_producer_stb", {31'd0, o_stb}, 32'd1);
        idle(1'b0, 1'b1);
        chk("dep_stall_stb", {31'd0, o_stb}, 32'd0);
        idle(1'b1, 1'b0);
`ifdef ALU_ISSUE_BYPASS_EN
        chk("dep_bypass_stb", {31'd0, o_stb}, 32'd1);
        chk("dep_bypass_a", o_a, 32'd12);
        chk("dep_bypass_b", o_b, 32'd2);
        idle(1'b1, 1'b0);
`else
        chk("dep_wait_stb", {31'd0, o_stb}, 32'd0);
        idle(1'b0, 1'b0);
        chk("dep_patched_stb", {31'd0, o_stb}, 32'd1);
        chk("dep_patched_a", o_a, 32'd12);
        chk("dep_patched_b", o_b, 32'd2);
        idle(1'b1, 1'b0);
`endif
        idle(1'b0, 1'b0);

        // Multiply holding the ALU busy three cycles with the next op waiting.
        cyc(1'b0, 1'b1, OP_MPY, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_OR, 5'd10, 5'd11, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("busy_mpy_stb", {31'd0, o_stb}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, OP_XOR, 5'd5, 5'd6, 5'd12, 1'b1, 1'b0, 1'b1);
            chk("busy_hold_stb", {31'd0, o_stb}, 32'd0);
            chk("busy_hold_ready", {31'd0, o_ready}, 32'd0);
        end
        cyc(1'b0, 1'b1, OP_XOR, 5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 1'b0);
        chk("busy_release_stb", {31'd0, o_stb}, 32'd1);
        chk("busy_release_ready", {31'd0, o_ready}, 32'd1);
        idle(1'b1, 1'b0);
        chk("busy_next_stb", {31'd0, o_stb}, 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Writeback port: OR r9 = 0xDEAD0000 | 0x0000BEEF.
        cyc(1'b0, 1'b1, OP_OR, 5'd10, 5'd11, 5'd9, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("wb_issue_stb", {31'd0, o_stb}, 32'd1);
        idle(1'b1, 1'b0);
        chk("wb_port_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("wb_port_reg", {27'd0, o_wb_reg}, 32'd9);
        chk("wb_port_data", o_wb_data, 32'hDEADBEEF);
        idle(1'b0, 1'b0);

        // Non-writing op followed by a reader of the same register number: no stall.
        cyc(1'b0, 1'b1, OP_ADD, 5'd5, 5'd6, 5'd12, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_SUB, 5'd12, 5'd5, 5'd13, 1'b1, 1'b0, 1'b0);
        chk("nowen_first_stb", {31'd0, o_stb}, 32'd1);
        idle(1'b1, 1'b0);
        chk("nowen_second_stb", {31'd0, o_stb}, 32'd1);
        chk("nowen_no_wb", {31'd0, o_wb_valid}, 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Reset with a buffered, stalled op and an in-flight write; the late result is dropped.
        cyc(1'b0, 1'b1, OP_ADD, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 5'd9, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_issue_stb", {31'd0, o_stb}, 32'd1);
        idle(1'b0, 1'b0);
        chk("rst_pre_stall_stb", {31'd0, o_stb}, 32'd0);
        chk("rst_pre_stall_ready", {31'd0, o_ready}, 32'd0);
        cyc(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        iss_q.delete();
        wb_q.delete();
        alu_q.delete();
        idle(1'b1, 1'b0);
        chk("rst_post_stb", {31'd0, o_stb}, 32'd0);
        chk("rst_post_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_late_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        load_rf();
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Randomized traffic over a small register set to provoke hazards.
        auto_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cyc(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end
        begin
            int t;
            t = 0;
            while ((iss_q.size() != 0 || wb_q.size() != 0) && t < 200) begin
                idle(1'b0, 1'b0);
                t++;
            end
        end
        idle(1'b0, 1'b0);
        chk("drain_issue_q", iss_q.size(), 32'd0);
        chk("drain_wb_q", wb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL have: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: i_valid  in  1  decode presents an op.
REQ-004 SHALL have: o_ready  out  1  op accepted when i_valid && o_ready.
REQ-005 SHALL have: i_op  in  4  ALU opcode, passed unmodified.
REQ-006 SHALL have: i_areg, i_breg, i_wreg  in  5 each  source A, source B, destination register numbers.
REQ-007 SHALL have: i_wen  in  1  op writes i_wreg.
REQ-008 SHALL have: i_a, i_b  in  32 each  register-file operand values.
REQ-009 SHALL have: o_stb  out  1  issue strobe to ALU.
REQ-010 SHALL have: o_op  out  4  opcode; o_a, o_b  out  32 each  operands to ALU.
REQ-011 SHALL have: i_alu_valid  in  1  ALU result valid.
REQ-012 SHALL have: i_alu_busy  in  1  ALU busy (multiply in progress).
REQ-013 SHALL have: i_alu_c  in  32  ALU result.
REQ-014 SHALL have: o_wb_valid  out  1, o_wb_reg  out  5, o_wb_data  out  32  register-file write port.

Function
REQ-015 SHALL hold one buffered op (buf_valid, op, regs, wen, A, B); accepted ops enter the buffer, issue only from the buffer (1-cycle minimum accept-to-issue latency).
REQ-016 SHALL drive o_ready = !buf_valid || issue, combinationally; accept and issue in the same cycle permitted.
REQ-017 SHALL track one in-flight write: inflight, inflight_reg; set on issue with wen, cleared on i_alu_valid; set wins when both occur in the same cycle.
REQ-018 SHALL define hazard = inflight && (buf_areg==inflight_reg || buf_breg==inflight_reg) && !resolved, where resolved is per REQ-029/030.
REQ-019 SHALL assert o_stb = buf_valid && !i_alu_busy && !hazard; o_stb SHALL never assert while i_alu_busy.
REQ-020 SHALL drive o_wb_valid = i_alu_valid && inflight, o_wb_reg = inflight_reg, o_wb_data = i_alu_c, combinationally.
REQ-021 SHALL, on capture while i_alu_valid && inflight && source==inflight_reg, capture i_alu_c instead of i_a/i_b for that source.
REQ-022 SHALL, on capture in a cycle where an issuing op writes register X, treat incoming sources equal to X as hazards from the next cycle.
REQ-023 SHALL, while buffered and i_alu_valid && inflight match a buffered source, overwrite that buffered operand with i_alu_c at the clock edge.
REQ-024 SHALL pass o_op unmodified; o_a/o_b per REQ-029/030.
REQ-025 SHALL keep results in order; the ALU returns at most one result per issue.

Reset
REQ-026 SHALL on i_reset clear buf_valid and inflight; o_stb=0, o_wb_valid=0, o_ready=1 in the cycle following reset.
REQ-027 SHALL discard a buffered op and any in-flight tracking when i_reset asserts mid-operation; a late i_alu_valid SHALL not produce o_wb_valid.
REQ-028 SHALL not reset data registers (operands, regs, op).

Configuration
REQ-029 SHALL, with ALU_ISSUE_BYPASS_EN defined, treat a hazard as resolved in the cycle i_alu_valid matches, muxing i_alu_c combinationally onto o_a/o_b; dependent op issues the same cycle.
REQ-030 SHALL, without ALU_ISSUE_BYPASS_EN, never resolve combinationally; dependent op issues the cycle after i_alu_valid from the REQ-023 patched operand.

Verification
REQ-031 Independent ops ADD r1=r2+r3 then OR r4=r5|r6, back-to-back -> o_stb on consecutive cycles, o_ready held 1.
REQ-032 ADD r1 (A=5,B=7) then SUB r2=r1-r3 (r3=2), bypass on -> second o_stb the cycle i_alu_valid rises, o_a=12, o_b=2; bypass off -> one cycle later, o_a=12.
REQ-033 MPY r1 with i_alu_busy high 3 cycles, next independent op waiting -> o_stb held 0 until busy drops, o_ready 0 while buffer full.
REQ-034 i_alu_valid with i_alu_c=0xDEADBEEF while inflight_reg=9 -> o_wb_valid=1, o_wb_reg=9, o_wb_data=0xDEADBEEF.
REQ-035 i_reset asserted with buffered op and inflight set -> next cycle o_stb=0, o_ready=1; subsequent i_alu_valid -> o_wb_valid=0.
REQ-036 Op with i_wen=0 issued then dependent on same register number -> no stall, o_stb next cycle.
